// File: rtl/ips_frontend.sv
// Conditions the three raw IPS line sensors into clean, debounced L/C/R outputs
// with dropout hold, a line-lost flag and a one-cycle change pulse.
module ips_frontend #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_W     = 8,
    parameter int LOST_HOLD = 100,
    parameter int HOLD_W    = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic IPS_L,
    input  logic IPS_C,
    input  logic IPS_R,
    output logic L,
    output logic C,
    output logic R,
    output logic Lost,
    output logic Change
);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_HOLD  = 2'd1,
        ST_LOST  = 2'd2
    } state_e;

    logic [2:0]       raw_s;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       deb_q;
    logic [2:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       lcr_q;
    logic [2:0]       lcr_d;
    logic [2:0]       held_q;
    logic [2:0]       held_d;
    logic [HOLD_W-1:0] hcnt_q;
    logic [HOLD_W-1:0] hcnt_d;
    logic             lost_q;
    logic             lost_d;
    logic             change_q;
    logic             change_d;

    assign raw_s = {IPS_L, IPS_C, IPS_R};

    // Two-flop synchronisers for the asynchronous sensor pins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // A channel flips only after DEBOUNCE consecutive cycles of disagreement.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounced values and their disagreement counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Track/hold/lost sequencing; a returning line wins over the timeout.
    always_comb begin
        state_d = state_q;
        lcr_d   = lcr_q;
        held_d  = held_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            ST_TRACK: begin
                if (deb_q == 3'b000) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                    lcr_d   = held_q;
                end else begin
                    lcr_d  = deb_q;
                    held_d = deb_q;
                end
            end
            ST_HOLD: begin
                if (deb_q != 3'b000) begin
                    state_d = ST_TRACK;
                    lcr_d   = deb_q;
                    held_d  = deb_q;
                end else if (hcnt_q == HOLD_W'(LOST_HOLD - 1)) begin
                    state_d = ST_LOST;
                    lcr_d   = 3'b000;
                end else begin
                    hcnt_d = hcnt_q + HOLD_W'(1);
                    lcr_d  = held_q;
                end
            end
            ST_LOST: begin
                if (deb_q != 3'b000) begin
                    state_d = ST_TRACK;
                    lcr_d   = deb_q;
                    held_d  = deb_q;
                end else begin
                    lcr_d = 3'b000;
                end
            end
            default: begin
                state_d = ST_LOST;
                lcr_d   = 3'b000;
            end
        endcase
        lost_d   = (state_d == ST_LOST);
        change_d = (lcr_d != lcr_q);
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_LOST;
            lcr_q    <= 3'b000;
            held_q   <= 3'b000;
            hcnt_q   <= '0;
            lost_q   <= 1'b1;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lcr_q    <= lcr_d;
            held_q   <= held_d;
            hcnt_q   <= hcnt_d;
            lost_q   <= lost_d;
            change_q <= change_d;
        end
    end

    assign L      = lcr_q[2];
    assign C      = lcr_q[1];
    assign R      = lcr_q[0];
    assign Lost   = lost_q;
    assign Change = change_q;

endmodule

// File: tb/tb_ips_frontend.sv
// Directed, table-driven bench for ips_frontend with DEBOUNCE=4, LOST_HOLD=8.
module tb_ips_frontend;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic IPS_L = 1'b0;
    logic IPS_C = 1'b0;
    logic IPS_R = 1'b0;
    logic L, C, R, Lost, Change;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ips_frontend #(
        .DEBOUNCE (4),
        .CNT_W    (8),
        .LOST_HOLD(8),
        .HOLD_W   (16)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IPS_L (IPS_L),
        .IPS_C (IPS_C),
        .IPS_R (IPS_R),
        .L     (L),
        .C     (C),
        .R     (R),
        .Lost  (Lost),
        .Change(Change)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] raw;
        int         n;
        logic [2:0] lcr;
        logic       lost;
        logic       chg;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_raw(input logic [2:0] v);
        {IPS_L, IPS_C, IPS_R} = v;
    endtask

    task automatic check(input string name, input int idx, input logic [2:0] lcr,
                         input logic lost, input logic chg);
        total_cnt++;
        if ({L, C, R, Lost, Change} === {lcr, lost, chg}) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d] @%0t: got LCR=%b Lost=%b Change=%b, want LCR=%b Lost=%b Change=%b",
                     name, idx, $time, {L, C, R}, Lost, Change, lcr, lost, chg);
        end
    endtask

    initial begin
        vecs[0]  = '{3'b110, 4, 3'b010, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 2, 3'b010, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 1, 3'b110, 1'b0, 1'b1};
        vecs[3]  = '{3'b010, 1, 3'b110, 1'b0, 1'b0};
        vecs[4]  = '{3'b010, 2, 3'b110, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 1, 3'b010, 1'b0, 1'b1};
        vecs[6]  = '{3'b010, 1, 3'b010, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 6, 3'b010, 1'b0, 1'b0};
        vecs[8]  = '{3'b011, 1, 3'b011, 1'b0, 1'b1};
        vecs[9]  = '{3'b111, 7, 3'b111, 1'b0, 1'b1};
        vecs[10] = '{3'b111, 1, 3'b111, 1'b0, 1'b0};
        vecs[11] = '{3'b101, 7, 3'b101, 1'b0, 1'b1};
        vecs[12] = '{3'b010, 7, 3'b010, 1'b0, 1'b1};
        vecs[13] = '{3'b010, 1, 3'b010, 1'b0, 1'b0};

        // Reset with random inputs: outputs forced asynchronously and held.
        #2;
        set_raw(3'($urandom_range(0, 7)));
        RST = 1'b1;
        #1;
        check("rst_async", 0, 3'b000, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            set_raw(3'($urandom_range(0, 7)));
            tick();
            check("rst_hold", k, 3'b000, 1'b1, 1'b0);
        end
        set_raw(3'b000);
        RST = 1'b0;
        tick();
        check("rst_release", 0, 3'b000, 1'b1, 1'b0);

        // Centre sensor from LOST: visible at edge 7, single Change pulse.
        set_raw(3'b010);
        for (int e = 1; e <= 6; e++) tick();
        check("c_latency_pre", 6, 3'b000, 1'b1, 1'b0);
        tick();
        check("c_latency", 7, 3'b010, 1'b0, 1'b1);
        tick();
        check("c_pulse_end", 8, 3'b010, 1'b0, 1'b0);

        // Three-cycle left glitch is rejected.
        set_raw(3'b110);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 3) set_raw(3'b010);
            check("glitch3", e, 3'b010, 1'b0, 1'b0);
        end

        // Vector table: 4-cycle pulse accepted, then 011/111/101/010 patterns.
        for (int v = 0; v < 14; v++) begin
            set_raw(vecs[v].raw);
            for (int k = 0; k < vecs[v].n; k++) tick();
            check("vec", v, vecs[v].lcr, vecs[v].lost, vecs[v].chg);
        end

        // 8-cycle dropout: line returns on the timeout cycle and wins.
        set_raw(3'b000);
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("drop8", e, 3'b010, 1'b0, 1'b0);
            if (e == 8) set_raw(3'b010);
        end

        // 9-cycle dropout: times out for one cycle, then recovers.
        set_raw(3'b000);
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 9) set_raw(3'b010);
            if (e <= 14)      check("drop9", e, 3'b010, 1'b0, 1'b0);
            else if (e == 15) check("drop9", e, 3'b000, 1'b1, 1'b1);
            else if (e == 16) check("drop9", e, 3'b010, 1'b0, 1'b1);
            else              check("drop9", e, 3'b010, 1'b0, 1'b0);
        end
        for (int e = 1; e <= 3; e++) tick();

        // Permanent dropout: held through edge 14, lost at edge 15.
        set_raw(3'b000);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e <= 14)      check("lost", e, 3'b010, 1'b0, 1'b0);
            else if (e == 15) check("lost", e, 3'b000, 1'b1, 1'b1);
            else              check("lost", e, 3'b000, 1'b1, 1'b0);
        end

        // Recover from LOST.
        set_raw(3'b010);
        for (int e = 1; e <= 6; e++) tick();
        check("recover_pre", 6, 3'b000, 1'b1, 1'b0);
        tick();
        check("recover", 7, 3'b010, 1'b0, 1'b1);

        // Reset in HOLD with hcnt=5, then right sensor after release.
        set_raw(3'b000);
        for (int e = 1; e <= 12; e++) tick();
        check("hold_pre_rst", 12, 3'b010, 1'b0, 1'b0);
        set_raw(3'b001);
        RST = 1'b1;
        #1;
        check("rst_mid_hold", 0, 3'b000, 1'b1, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e < 7)       check("r_after_rst", e, 3'b000, 1'b1, 1'b0);
            else if (e == 7) check("r_after_rst", e, 3'b001, 1'b0, 1'b1);
            else             check("r_after_rst", e, 3'b001, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
